// File: rtl/fma16_pkg.sv
// Shared opcode, control and constant definitions for the fma16 issue stage.
package fma16_pkg;

  localparam logic [15:0] CANON_NAN = 16'h7E00;

  typedef enum logic [2:0] {
    OP_FADD    = 3'd0,
    OP_FSUB    = 3'd1,
    OP_FMUL    = 3'd2,
    OP_FMADD   = 3'd3,
    OP_FMSUB   = 3'd4,
    OP_FNMADD  = 3'd5,
    OP_FNMSUB  = 3'd6,
    OP_ILLEGAL = 3'd7
  } fma_op_e;

  typedef struct packed {
    logic mul;
    logic add;
    logic negr;
    logic negz;
  } fma_ctrl_t;

  // The illegal opcode decodes to all-zero controls so nothing reaches the datapath.
  function automatic fma_ctrl_t decode_op(input fma_op_e op);
    fma_ctrl_t c;
    c = '0;
    case (op)
      OP_FADD:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b0};
      OP_FSUB:   c = '{mul: 1'b0, add: 1'b1, negr: 1'b0, negz: 1'b1};
      OP_FMUL:   c = '{mul: 1'b1, add: 1'b0, negr: 1'b0, negz: 1'b0};
      OP_FMADD:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b0};
      OP_FMSUB:  c = '{mul: 1'b1, add: 1'b1, negr: 1'b0, negz: 1'b1};
      OP_FNMADD: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b0};
      OP_FNMSUB: c = '{mul: 1'b1, add: 1'b1, negr: 1'b1, negz: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fma16_req_fifo.sv
// Circular request FIFO with occupancy count; flush has priority over push/pop.
module fma16_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/fma16_issue.sv
// Issue stage for the fp16 fma16 datapath: buffers requests, decodes the head onto
// the combinational fma16 interface and registers its result with the request tag.
module fma16_issue
  import fma16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_op,
  input  logic [15:0]                 req_x,
  input  logic [15:0]                 req_y,
  input  logic [15:0]                 req_z,
  input  logic [1:0]                  req_rm,
  input  logic [TAGW-1:0]             req_tag,
  output logic [15:0]                 fma_x,
  output logic [15:0]                 fma_y,
  output logic [15:0]                 fma_z,
  output logic                        fma_mul,
  output logic                        fma_add,
  output logic                        fma_negr,
  output logic                        fma_negz,
  output logic [1:0]                  fma_rm,
  input  logic [15:0]                 fma_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [15:0]                 rsp_result,
  output logic [TAGW-1:0]             rsp_tag,
  output logic                        rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int EW = 3 + 16*3 + 2 + TAGW;

  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_issue;
  logic              w_legal;
  fma_op_e           w_head_op;
  logic [15:0]       w_head_x;
  logic [15:0]       w_head_y;
  logic [15:0]       w_head_z;
  logic [1:0]        w_head_rm;
  logic [TAGW-1:0]   w_head_tag;
  fma_ctrl_t         w_ctrl;

  logic              r_rsp_valid;
  logic [15:0]       r_rsp_result;
  logic [TAGW-1:0]   r_rsp_tag;
  logic              r_rsp_err;

  assign w_wdata = {req_op, req_x, req_y, req_z, req_rm, req_tag};

  fma16_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (req_valid),
    .pop   (w_issue),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (occupancy)
  );

  assign {w_head_op, w_head_x, w_head_y, w_head_z, w_head_rm, w_head_tag} = w_rdata;

  assign req_ready = !w_full;
  assign w_issue   = !w_empty && (!r_rsp_valid || rsp_ready);
  assign w_legal   = !w_empty && (w_head_op != OP_ILLEGAL);

  // Operands and controls are quiet whenever there is no legal op at the head.
  always_comb begin
    w_ctrl = '0;
    fma_x  = '0;
    fma_y  = '0;
    fma_z  = '0;
    fma_rm = '0;
    if (w_legal) begin
      w_ctrl = decode_op(w_head_op);
      fma_x  = w_head_x;
      fma_y  = w_head_y;
      fma_z  = w_head_z;
      fma_rm = w_head_rm;
    end
  end

  assign fma_mul  = w_ctrl.mul;
  assign fma_add  = w_ctrl.add;
  assign fma_negr = w_ctrl.negr;
  assign fma_negz = w_ctrl.negz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
    end else if (flush) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_issue) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= w_legal ? fma_result : CANON_NAN;
      r_rsp_tag    <= w_head_tag;
      r_rsp_err    <= !w_legal;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_fma16_issue.sv
// Self-checking bench for fma16_issue: an integer-domain fma16 stand-in drives fma_result,
// and a queue-based model of the issue stage is compared against the DUT every cycle.
module tb_fma16_issue;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  // Controls {mul,add,negr,negz} indexed by opcode; opcode 7 is illegal.
  localparam logic [3:0] CTRL_TABLE [8] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100,
                                            4'b1101, 4'b1110, 4'b1111, 4'b0000};

  typedef struct packed {
    logic [2:0]      op;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [15:0]     z;
    logic [1:0]      rm;
    logic [TAGW-1:0] tag;
  } req_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [15:0]       req_x, req_y, req_z;
  logic [1:0]        req_rm;
  logic [TAGW-1:0]   req_tag;
  logic [15:0]       fma_x, fma_y, fma_z;
  logic              fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]        fma_rm;
  logic [15:0]       fma_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_result;
  logic [TAGW-1:0]   rsp_tag;
  logic              rsp_err;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  int nChecks = 0;
  int nPass   = 0;

  req_t            mq[$];
  logic            mValid;
  logic [15:0]     mResult;
  logic [TAGW-1:0] mTag;
  logic            mErr;

  fma16_issue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_z      (req_z),
    .req_rm     (req_rm),
    .req_tag    (req_tag),
    .fma_x      (fma_x),
    .fma_y      (fma_y),
    .fma_z      (fma_z),
    .fma_mul    (fma_mul),
    .fma_add    (fma_add),
    .fma_negr   (fma_negr),
    .fma_negz   (fma_negz),
    .fma_rm     (fma_rm),
    .fma_result (fma_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact fp16 encoding of small integers.
  function automatic logic [15:0] fp16Of(input int v);
    int m;
    int e;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((1 << (e + 1)) <= m) e++;
    return {s, 5'(15 + e), 10'((m - (1 << e)) << (10 - e))};
  endfunction

  function automatic int intOf(input logic [15:0] h);
    for (int i = -64; i <= 64; i++) begin
      if (fp16Of(i) == h) return i;
    end
    return 0;
  endfunction

  // fma16 stand-in: r = +/-((mul ? x*y : x) + (add ? +/-z : 0)), exact over small integers.
  function automatic logic [15:0] fakeFma(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z, input logic [3:0] c);
    int r;
    r = c[3] ? intOf(x) * intOf(y) : intOf(x);
    if (c[2]) r = r + (c[0] ? -intOf(z) : intOf(z));
    if (c[1]) r = -r;
    return fp16Of(r);
  endfunction

  assign fma_result = fakeFma(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negr, fma_negz});

  function automatic logic [15:0] expectedResult(input req_t r);
    if (r.op == 3'd7) return 16'h7E00;
    return fakeFma(r.x, r.y, r.z, CTRL_TABLE[r.op]);
  endfunction

  function automatic logic [53:0] expectedFma(input req_t r);
    if (r.op == 3'd7) return '0;
    return {r.x, r.y, r.z, r.rm, CTRL_TABLE[r.op]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model of the issue stage, stepped on each active edge.
  initial begin
    mValid = 1'b0; mResult = '0; mTag = '0; mErr = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mValid = 1'b0; mResult = '0; mTag = '0; mErr = 1'b0;
      end else if (flush) begin
        mq.delete();
        mValid = 1'b0;
      end else begin
        bit canPush;
        canPush = (mq.size() < DEPTH);
        if (mq.size() > 0 && (!mValid || rsp_ready)) begin
          req_t h;
          h = mq.pop_front();
          mValid  = 1'b1;
          mResult = expectedResult(h);
          mTag    = h.tag;
          mErr    = (h.op == 3'd7);
        end else if (mValid && rsp_ready) begin
          mValid = 1'b0;
        end
        if (req_valid && canPush)
          mq.push_back('{op: req_op, x: req_x, y: req_y, z: req_z, rm: req_rm, tag: req_tag});
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
        checkOutput("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(mValid));
        if (mValid) begin
          checkOutput("rsp_result", 64'(rsp_result), 64'(mResult));
          checkOutput("rsp_tag", 64'(rsp_tag), 64'(mTag));
          checkOutput("rsp_err", 64'(rsp_err), 64'(mErr));
        end
        checkOutput("fma_drive",
                    64'({fma_x, fma_y, fma_z, fma_rm, fma_mul, fma_add, fma_negr, fma_negz}),
                    64'((mq.size() > 0) ? expectedFma(mq[0]) : 54'd0));
      end
    end
  end

  // Presents one request and returns one step after the edge that accepts it.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z, input logic [1:0] rm,
                               input logic [TAGW-1:0] tag);
    bit acc;
    req_valid = 1'b1;
    req_op = op; req_x = x; req_y = y; req_z = z; req_rm = rm; req_tag = tag;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("req_accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] randSmall();
    return fp16Of(int'($urandom_range(0, 6)) - 3);
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_result"}, 64'(rsp_result), 64'h0000);
    checkOutput({tag, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_rm = '0; req_tag = '0;
    #1 rst_n = 1'b0;
    #2 checkResetValues("reset");
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] directed: fmadd latency and decode");
    applyStimulus(3'd3, 16'h3C00, 16'h4000, 16'h4200, 2'b01, 4'd5);
    @(negedge clk);
    checkOutput("t1_ctrl", 64'({fma_mul, fma_add, fma_negr, fma_negz}), 64'b1100);
    checkOutput("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("t1_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t1_result", 64'(rsp_result), 64'h4500);
    checkOutput("t1_tag", 64'(rsp_tag), 64'd5);

    applyStimulus(3'd1, 16'h4200, 16'h4400, 16'h3C00, 2'b00, 4'd2);
    @(negedge clk);
    checkOutput("t2_ctrl", 64'({fma_mul, fma_add, fma_negr, fma_negz}), 64'b0101);
    @(negedge clk);
    checkOutput("t2_result", 64'(rsp_result), 64'h4000);
    checkOutput("t2_err", 64'(rsp_err), 64'd0);

    applyStimulus(3'd7, 16'h4200, 16'h4200, 16'h4200, 2'b10, 4'd9);
    @(negedge clk);
    checkOutput("t3_quiet", 64'({fma_x, fma_mul, fma_add, fma_negr, fma_negz}), 64'd0);
    @(negedge clk);
    checkOutput("t3_nan", 64'(rsp_result), 64'h7E00);
    checkOutput("t3_err", 64'(rsp_err), 64'd1);
    @(posedge clk); #1;
    applyStimulus(3'd0, 16'h3C00, 16'h0000, 16'h3C00, 2'b01, 4'd10);
    idleCycles(1);
    @(negedge clk);
    checkOutput("t3_next_result", 64'(rsp_result), 64'h4000);
    checkOutput("t3_next_err", 64'(rsp_err), 64'd0);
    idleCycles(3);

    $display("[TB] directed: backpressure");
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(3'($urandom_range(0, 6)), randSmall(), randSmall(), randSmall(),
                    2'($urandom_range(0, 3)), TAGW'(i));
    req_valid = 1'b1; req_op = 3'd2; req_x = 16'h4000; req_y = 16'h4200;
    req_tag = TAGW'(DEPTH + 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_full_occ", 64'(occupancy), 64'(DEPTH));
    checkOutput("t4_full_ready", 64'(req_ready), 64'd0);
    checkOutput("t4_hold_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    applyStimulus(3'd2, 16'h4000, 16'h4200, 16'h0000, 2'b00, TAGW'(DEPTH + 1));
    idleCycles(DEPTH + 3);

    $display("[TB] directed: flush");
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(3'd0, randSmall(), randSmall(), randSmall(), 2'b01, TAGW'(i + 3));
    @(negedge clk);
    checkOutput("t5_pre_occ", 64'(occupancy), 64'd3);
    checkOutput("t5_pre_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_occ", 64'(occupancy), 64'd0);
    checkOutput("t5_valid", 64'(rsp_valid), 64'd0);
    checkOutput("t5_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    $display("[TB] directed: async reset mid-stream");
    for (int i = 0; i < 3; i++)
      applyStimulus(3'd3, randSmall(), randSmall(), randSmall(), 2'b11, TAGW'(i + 7));
    #2 rst_n = 1'b0;
    #1 checkResetValues("t6");
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    applyStimulus(3'd2, 16'h4000, 16'hC200, 16'h0000, 2'b01, 4'd12);
    @(negedge clk);
    checkOutput("t6_not_yet_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("t6_valid", 64'(rsp_valid), 64'd1);
    checkOutput("t6_result", 64'(rsp_result), 64'hC600);
    checkOutput("t6_tag", 64'(rsp_tag), 64'd12);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = 3'($urandom_range(0, 7));
      req_x     = randSmall();
      req_y     = randSmall();
      req_z     = randSmall();
      req_rm    = 2'($urandom_range(0, 3));
      req_tag   = TAGW'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    idleCycles(DEPTH + 4);
    @(negedge clk);
    checkOutput("drain_occ", 64'(occupancy), 64'd0);
    checkOutput("drain_valid", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
